user_input_bank: RTL and testbench
==================================

# user_input_bank

Parametrised bank of user-input conditioners. Each of `N` raw asynchronous key or switch inputs is synchronised and debounced. Each channel then produces a one-cycle `press` pulse per accepted press, a `release` pulse per accepted release, and optional auto-repeat pulses while held. The bank sits between board I/O and the game control FSMs (paddle move, launch, pause) and supersedes per-key single-pulse conditioners.

## Interface
Parameters:
- `N`, 4: channel count, ≥1.
- `DEBOUNCE_CYCLES`, 4: consecutive cycles a synchronised input must differ from `level` before `level` flips, ≥1.
- `REPEAT_DELAY`, 16: cycles from `press` pulse to first repeat pulse, ≥2.
- `REPEAT_PERIOD`, 4: cycles between subsequent repeat pulses, ≥1.

Ports:
- `clk` in 1: single clock; all state on posedge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `key` in N: raw inputs, active-high, asynchronous to `clk`.
- `level` out N: debounced registered input level.
- `press` out N: one-cycle pulse on accepted rising edge, plus repeat pulses when enabled.
- `release` out N: one-cycle pulse on accepted falling edge.

## Operation
- Channels are fully independent, and all logic is replicated per channel.
- Synchroniser: `key[i]` feeds `s1`, which feeds `s2` (two flops). Only `s2` is used downstream.
- Debounce counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s2 == level`, the counter clears to 0.
  - Otherwise, if counter == `DEBOUNCE_CYCLES-1`, `level` toggles and the counter clears.
  - Otherwise the counter increments.
- Any agreeing sample restarts the count, so a glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `level`.
- `press`/`release` are registered. They are set at the same edge `level` toggles 0→1 or 1→0, and clear at the next edge unless re-triggered.
- Auto-repeat (only with `USER_INPUT_REPEAT_EN`): per-channel repeat counter of width `$clog2(REPEAT_DELAY+1)`.
  - The counter loads `REPEAT_DELAY-1` at the edge `level` rises.
  - While `level` is high it decrements each cycle.
  - On reaching 0 it asserts `press` for one cycle and reloads `REPEAT_PERIOD-1`.
  - When `level` falls, the counter is held at 0 and idle.
- States per channel: IDLE (`level`=0), HELD (`level`=1). Transitions occur only via the debounce rule.

## Timing
- Reset values: `level`, `press`, `release`, `s1`, `s2`, all counters = 0.
- Latency: `key` sampled high at edge k gives `s2` high after edge k+1, then `level` and `press` high after edge k+1+`DEBOUNCE_CYCLES`. Total is `DEBOUNCE_CYCLES`+2 edges including the sampling edge.
- `DEBOUNCE_CYCLES`=1 reduces to a synchronised edge detector: `level` follows `s2` one edge later.
- First repeat asserts `REPEAT_DELAY` cycles after the initial `press`. Subsequent repeats follow every `REPEAT_PERIOD` cycles. `REPEAT_PERIOD`=1 gives `press` high continuously after the delay.
- Release during a repeat countdown: `release` pulses, and no further repeat fires, including one that would have coincided with the falling edge.
- `press` and `release` are never high in the same cycle on one channel.
- Reset mid-operation: outputs drop asynchronously. A key still held after deassertion is treated as a fresh press: `press` fires `DEBOUNCE_CYCLES`+2 edges after the first sampling edge.
- Simultaneous activity on different channels is fully independent, with no arbitration.

## Configuration
- `USER_INPUT_REPEAT_EN`
  - Defined: auto-repeat logic is compiled in as described above.
  - Undefined: repeat counters are absent, `press` fires exactly once per accepted rising edge, and `REPEAT_DELAY`/`REPEAT_PERIOD` are ignored.
  - Debounce, `level` and `release` behaviour is identical in both builds.

## Test plan
- Reset with `N`=4, `DEBOUNCE_CYCLES`=4 and `key`=4'b1111 held: all outputs stay 0 while `reset`=1. After deassertion, `press`=4'b1111 for exactly one cycle at the 6th edge, and `level`=4'b1111 thereafter.
- Glitch: `key[0]` high for 3 cycles, then low → `level`, `press`, `release` remain 0. The same pulse for 6 cycles gives one `press[0]` pulse, then one `release[0]` pulse 6 edges after the fall.
- Bounce: `key[1]` toggles 1,0,1,0,1 on consecutive cycles, then stays 1 → exactly one `press[1]` pulse, `DEBOUNCE_CYCLES` edges after the last agreeing run begins in `s2`.
- Repeat (macro defined, `REPEAT_DELAY`=16, `REPEAT_PERIOD`=4): hold `key[2]` 40 cycles → `press[2]` pulses at t0, t0+16, t0+20, t0+24, …; on release, a `release[2]` pulse and no further pulses.
- Macro undefined, same stimulus → a single `press[2]` pulse at t0 and a single `release[2]` pulse.
- Independence: `key[0]` and `key[3]` asserted on the same cycle while `key[1]` is releasing → `press[0]` and `press[3]` coincide, `release[1]` is unaffected, and `level[2]`=0 throughout.

Source files
------------

// File: rtl/user_input_bank.sv
// rtl/user_input_bank.sv - N-channel key/switch synchroniser + debouncer with press/release pulses
// Optional auto-repeat on held keys is compiled in with USER_INPUT_REPEAT_EN.
module user_input_bank #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] key,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    if (N < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("user_input_bank: parameter out of range");
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          s1;
        logic          s2;
        state_t        state;
        state_t        state_nxt;
        logic [DW-1:0] cnt;
        logic [DW-1:0] cnt_nxt;
        logic          press_q;
        logic          press_nxt;
        logic          rel_q;
        logic          rel_nxt;
        logic          rise;
        logic          fall;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1      <= 1'b0;
                s2      <= 1'b0;
                state   <= IDLE;
                cnt     <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                s1      <= key[i];
                s2      <= s1;
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                press_q <= press_nxt;
                rel_q   <= rel_nxt;
            end
        end

        // Any sample agreeing with the current level restarts the run.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            rise      = 1'b0;
            fall      = 1'b0;
            if (s2 == (state == HELD)) begin
                cnt_nxt = '0;
            end else if (cnt == DB_LAST) begin
                cnt_nxt = '0;
                unique case (state)
                    IDLE: begin
                        state_nxt = HELD;
                        rise      = 1'b1;
                    end
                    HELD: begin
                        state_nxt = IDLE;
                        fall      = 1'b1;
                    end
                endcase
            end else begin
                cnt_nxt = cnt + DW'(1);
            end
        end

`ifdef USER_INPUT_REPEAT_EN
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW   = $clog2(RMAX + 1);
        localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD - 1);

        logic [RW-1:0] rcnt;
        logic [RW-1:0] rcnt_nxt;
        logic          rep;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rcnt <= '0;
            end else begin
                rcnt <= rcnt_nxt;
            end
        end

        // A falling edge wins over a repeat that would fire on the same edge.
        always_comb begin
            rcnt_nxt = rcnt;
            rep      = 1'b0;
            if (rise) begin
                rcnt_nxt = R_DELAY;
            end else if (state == HELD && !fall) begin
                if (rcnt == '0) begin
                    rep      = 1'b1;
                    rcnt_nxt = R_PERIOD;
                end else begin
                    rcnt_nxt = rcnt - RW'(1);
                end
            end else begin
                rcnt_nxt = '0;
            end
        end

        assign press_nxt = rise | rep;
`else
        assign press_nxt = rise;
`endif
        assign rel_nxt = fall;

        assign level[i]         = (state == HELD);
        assign press[i]         = press_q;
        assign release_pulse[i] = rel_q;
    end

endmodule

// File: tb/tb_user_input_bank.sv
// tb/tb_user_input_bank.sv - directed vector bench for user_input_bank (N=4, DEBOUNCE_CYCLES=4)
module tb_user_input_bank;

    localparam int N  = 4;
    localparam int DC = 4;
    localparam int RD = 16;
    localparam int RP = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] key;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] release_pulse;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    user_input_bank #(
        .N(N),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key(key),
        .level(level),
        .press(press),
        .release_pulse(release_pulse)
    );

    typedef struct {
        logic [3:0] key;
        int         cyc;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [3:0] l, input logic [3:0] p, input logic [3:0] r);
        check({name, " level"}, level, l);
        check({name, " press"}, press, p);
        check({name, " release"}, release_pulse, r);
    endtask

    initial begin
        // reset held with all keys high, then 6th edge after release
        vt.push_back('{4'b1111, 5, 4'b0000, 4'b0000, 4'b0000});
        vt.push_back('{4'b1111, 1, 4'b1111, 4'b1111, 4'b0000});
        vt.push_back('{4'b1111, 3, 4'b1111, 4'b0000, 4'b0000});
        vt.push_back('{4'b0000, 5, 4'b1111, 4'b0000, 4'b0000});
        vt.push_back('{4'b0000, 1, 4'b0000, 4'b0000, 4'b1111});
        vt.push_back('{4'b0000, 3, 4'b0000, 4'b0000, 4'b0000});
        // 3-cycle glitch on key[0]
        vt.push_back('{4'b0001, 3, 4'b0000, 4'b0000, 4'b0000});
        vt.push_back('{4'b0000, 6, 4'b0000, 4'b0000, 4'b0000});
        // 6-cycle pulse on key[0]
        vt.push_back('{4'b0001, 5, 4'b0000, 4'b0000, 4'b0000});
        vt.push_back('{4'b0001, 1, 4'b0001, 4'b0001, 4'b0000});
        vt.push_back('{4'b0000, 5, 4'b0001, 4'b0000, 4'b0000});
        vt.push_back('{4'b0000, 1, 4'b0000, 4'b0000, 4'b0001});
        vt.push_back('{4'b0000, 2, 4'b0000, 4'b0000, 4'b0000});
        // bounce on key[1]: 1,0,1,0,1 then held
        vt.push_back('{4'b0010, 1, 4'b0000, 4'b0000, 4'b0000});
        vt.push_back('{4'b0000, 1, 4'b0000, 4'b0000, 4'b0000});
        vt.push_back('{4'b0010, 1, 4'b0000, 4'b0000, 4'b0000});
        vt.push_back('{4'b0000, 1, 4'b0000, 4'b0000, 4'b0000});
        vt.push_back('{4'b0010, 5, 4'b0000, 4'b0000, 4'b0000});
        vt.push_back('{4'b0010, 1, 4'b0010, 4'b0010, 4'b0000});
        vt.push_back('{4'b0010, 3, 4'b0010, 4'b0000, 4'b0000});
        // key[0],key[3] pressed on the cycle key[1] releases
        vt.push_back('{4'b1001, 5, 4'b0010, 4'b0000, 4'b0000});
        vt.push_back('{4'b1001, 1, 4'b1001, 4'b1001, 4'b0010});
        vt.push_back('{4'b1001, 2, 4'b1001, 4'b0000, 4'b0000});
        vt.push_back('{4'b0000, 5, 4'b1001, 4'b0000, 4'b0000});
        vt.push_back('{4'b0000, 1, 4'b0000, 4'b0000, 4'b1001});
        vt.push_back('{4'b0000, 2, 4'b0000, 4'b0000, 4'b0000});

        reset = 1'b1;
        key   = 4'b1111;
        #1;
        check_all("reset async", 4'b0000, 4'b0000, 4'b0000);
        for (int c = 0; c < 3; c++) begin
            step();
            check_all($sformatf("reset hold%0d", c), 4'b0000, 4'b0000, 4'b0000);
        end
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            for (int c = 0; c < vt[i].cyc; c++) begin
                key = vt[i].key;
                step();
                check_all($sformatf("vec%0d.%0d", i, c), vt[i].lvl, vt[i].prs, vt[i].rel);
            end
        end

        // key[2] held 40 cycles: t0 at edge 5, fall at edge 45
        for (int c = 0; c < 60; c++) begin
            logic ep;
            key = (c < 40) ? 4'b0100 : 4'b0000;
            step();
`ifdef USER_INPUT_REPEAT_EN
            ep = (c == 5) || (c >= 21 && c <= 41 && ((c - 21) % RP) == 0);
`else
            ep = (c == 5);
`endif
            check($sformatf("hold c%0d press", c), press, {1'b0, ep, 2'b00});
            check($sformatf("hold c%0d release", c), release_pulse, {1'b0, (c == 45), 2'b00});
            check($sformatf("hold c%0d level", c), level, {1'b0, (c >= 5 && c < 45), 2'b00});
            check($sformatf("hold c%0d overlap", c), press & release_pulse, 4'b0000);
        end

        // reset while key[3] is held, then fresh press after deassertion
        key = 4'b1000;
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("pre-reset c%0d press", c), press, (c == 5) ? 4'b1000 : 4'b0000);
        end
        check("pre-reset level", level, 4'b1000);
        reset = 1'b1;
        #1;
        check_all("mid reset async", 4'b0000, 4'b0000, 4'b0000);
        step();
        step();
        check_all("mid reset hold", 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("post-reset c%0d press", c), press, (c == 5) ? 4'b1000 : 4'b0000);
            check($sformatf("post-reset c%0d level", c), level, (c >= 5) ? 4'b1000 : 4'b0000);
            check($sformatf("post-reset c%0d release", c), release_pulse, 4'b0000);
        end
        key = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("post-reset fall c%0d release", c), release_pulse, (c == 5) ? 4'b1000 : 4'b0000);
            check($sformatf("post-reset fall c%0d press", c), press, 4'b0000);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
